// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared state type and default word width for the I2S sample receiver
package i2s_rx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;
  localparam int SAMPLE_W_DEF = 16;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer for a pin bus with a rising-edge strobe on bit 0
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous pins; bit 0 is the edge-detected one
//   q_o      : synchronized copies of bits [W-1:1], aligned with rise_o
//   rise_o   : one-clk strobe when synchronized bit 0 goes 0 -> 1
module sync_edge_det #(
  parameter int W      = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:1] q_o,
  output logic         rise_o
);
  logic [STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0] prev_q;
  logic rise_q;
  // The strobe is registered, so the data bits are taken one stage later to stay aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1][0] & ~prev_q[0];
    end
  end
  assign q_o    = prev_q[W-1:1];
  assign rise_o = rise_q;
endmodule

// File: rtl/i2s_sample_receiver.sv
// i2s_sample_receiver: oversampling I2S deserializer producing signed PCM words on clk
//   clk, rst     : system clock (>= 4x sck), synchronous active-high reset
//   i2s_sck/ws/sd: asynchronous I2S pins (ws 0 = left, 1 = right)
//   sample_out   : captured word, held until the next emit
//   sample_valid : one-clk pulse, sample_out valid
//   sample_chan  : channel of sample_out
//   frame_err    : one-clk pulse, slot ended before SAMPLE_W bits arrived
//   I2S_MONO_MIX_EN: when defined, emit floor((L+R)/2) once per complete frame on channel 0
module i2s_sample_receiver
  import i2s_rx_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i2s_sck,
  input  logic                       i2s_ws,
  input  logic                       i2s_sd,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic                       sample_chan,
  output logic                       frame_err
);
  localparam int CW = $clog2(SAMPLE_W + 1);
  logic ws_s, sd_s, sck_rise;
  state_e state_q;
  logic [SAMPLE_W-1:0] shreg_q, word_d;
  logic [CW-1:0] bit_cnt_q;
  logic ws_prev_q, chan_q, done_d, slot_d, err_d;
  sync_edge_det #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({i2s_ws, i2s_sd, i2s_sck}),
    .q_o    ({ws_s, sd_s}),
    .rise_o (sck_rise)
  );
  // Completion is checked before the slot boundary, so a 16-bit slot's LSB that
  // arrives with the ws change still finishes the word without an error.
  always_comb begin
    word_d = {shreg_q[SAMPLE_W-2:0], sd_s};
    done_d = (state_q == SHIFT) && (bit_cnt_q == CW'(SAMPLE_W - 1));
    slot_d = ws_s != ws_prev_q;
    err_d  = slot_d && (state_q == SHIFT) && !done_d;
  end
`ifdef I2S_MONO_MIX_EN
  logic [SAMPLE_W-1:0] left_q;
  logic left_ok_q;
  logic [SAMPLE_W:0] sum_d;
  always_comb sum_d = {left_q[SAMPLE_W-1], left_q} + {word_d[SAMPLE_W-1], word_d};
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      ws_prev_q    <= 1'b0;
      chan_q       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sample_chan  <= 1'b0;
      frame_err    <= 1'b0;
`ifdef I2S_MONO_MIX_EN
      left_q       <= '0;
      left_ok_q    <= 1'b0;
`endif
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (sck_rise) begin
        ws_prev_q <= ws_s;
        frame_err <= err_d;
        if (state_q == SHIFT) begin
          shreg_q   <= word_d;
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (done_d) begin
          state_q <= WAIT;
`ifdef I2S_MONO_MIX_EN
          if (!chan_q) begin
            left_q    <= word_d;
            left_ok_q <= 1'b1;
          end else begin
            left_ok_q <= 1'b0;
            if (left_ok_q) begin
              sample_out   <= sum_d[SAMPLE_W:1];
              sample_valid <= 1'b1;
              sample_chan  <= 1'b0;
            end
          end
`else
          sample_out   <= word_d;
          sample_valid <= 1'b1;
          sample_chan  <= chan_q;
`endif
        end
`ifdef I2S_MONO_MIX_EN
        if (err_d || (slot_d && !ws_s)) left_ok_q <= 1'b0;
`endif
        if (slot_d) begin
          chan_q    <= ws_s;
          bit_cnt_q <= '0;
          state_q   <= SHIFT;
        end
      end
    end
  end
endmodule
